// File: rtl/fft_in_framer_pkg.sv
// Shared definitions for the FFT input framer: default geometry and the
// output-side FSM state encoding.
package fft_in_framer_pkg;

    localparam int unsigned DEF_WIDTH       = 9;
    localparam int unsigned DEF_DATA_WIDTH  = 16;
    localparam int unsigned DEF_FRAME_BEATS = 32;
    localparam int unsigned DEF_GAP_CYCLES  = 17;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2
    } rd_state_e;

endpackage

// File: rtl/framer_bank.sv
// One frame buffer: synchronous write port, registered read port.
// Ports:
//   clk, rstn          clock, synchronous active-low reset (read register only)
//   wr_en/waddr/wdata  write one beat (all lanes, re and im)
//   rd_en/raddr        read one beat; rdata shows it after the edge
//   rdata_re/rdata_im  registered read data, zero whenever rd_en was low
module framer_bank
    import fft_in_framer_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned FRAME_BEATS = DEF_FRAME_BEATS,
    localparam int unsigned AW         = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             wr_en,
    input  logic [AW-1:0]                    waddr,
    input  logic [DATA_WIDTH-1:0][WIDTH-1:0] wdata_re,
    input  logic [DATA_WIDTH-1:0][WIDTH-1:0] wdata_im,
    input  logic                             rd_en,
    input  logic [AW-1:0]                    raddr,
    output logic [DATA_WIDTH-1:0][WIDTH-1:0] rdata_re,
    output logic [DATA_WIDTH-1:0][WIDTH-1:0] rdata_im
);

    logic [DATA_WIDTH-1:0][WIDTH-1:0] mem_re [FRAME_BEATS];
    logic [DATA_WIDTH-1:0][WIDTH-1:0] mem_im [FRAME_BEATS];

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_re[waddr] <= wdata_re;
            mem_im[waddr] <= wdata_im;
        end
    end

    // Read register returns zero when idle so the two banks can be OR-ed.
    always_ff @(posedge clk) begin
        if (!rstn || !rd_en) begin
            rdata_re <= '0;
            rdata_im <= '0;
        end else begin
            rdata_re <= mem_re[raddr];
            rdata_im <= mem_im[raddr];
        end
    end

endmodule

// File: rtl/fft_in_framer.sv
// Ping-pong framer in front of butterfly_0_0: collects FRAME_BEATS beats per
// bank, then streams a whole frame with valid_0_0 high and no stalls,
// followed by GAP_CYCLES idle cycles so the butterfly can drain.
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   in_valid/in_ready  upstream handshake (in_ready decoded from registers)
//   din_re/din_im      input lanes
//   dout_re/dout_im    registered output lanes, zero when valid_0_0 is low
//   valid_0_0          high for exactly FRAME_BEATS cycles per frame
module fft_in_framer
    import fft_in_framer_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned FRAME_BEATS = DEF_FRAME_BEATS,
    parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH-1:0][WIDTH-1:0] din_re,
    input  logic [DATA_WIDTH-1:0][WIDTH-1:0] din_im,
    output logic [DATA_WIDTH-1:0][WIDTH-1:0] dout_re,
    output logic [DATA_WIDTH-1:0][WIDTH-1:0] dout_im,
    output logic                             valid_0_0
);

    localparam int unsigned CW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    logic [1:0]    full;
    logic          wr_bank, rd_bank;
    logic [CW-1:0] wr_cnt, rd_cnt;
    logic [GW-1:0] gap_cnt;
    rd_state_e     state, state_n;

    logic accept, wr_last, rd_last, load, rd_clr;

    logic [DATA_WIDTH-1:0][WIDTH-1:0] bank_re [2];
    logic [DATA_WIDTH-1:0][WIDTH-1:0] bank_im [2];

    assign in_ready = ~full[wr_bank];
    assign accept   = in_valid & in_ready;
    assign wr_last  = (wr_cnt == CW'(FRAME_BEATS - 1));
    assign rd_last  = (rd_cnt == CW'(FRAME_BEATS - 1));
    assign rd_clr   = load & rd_last;

    // Write side: fill wr_bank, mark it full and flip on the last beat.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (accept) begin
            if (wr_last) begin
                wr_cnt  <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_cnt <= wr_cnt + CW'(1);
            end
        end
    end

    // Full flags: set by the writer, cleared by the reader. A bank is only
    // written while empty and only read while full, so the two never collide.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            full <= '0;
        end else begin
            if (accept && wr_last) full[wr_bank] <= 1'b1;
            if (rd_clr)            full[rd_bank] <= 1'b0;
        end
    end

    // Output FSM state register and read-side counters.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            rd_cnt    <= '0;
            rd_bank   <= 1'b0;
            gap_cnt   <= '0;
            valid_0_0 <= 1'b0;
        end else begin
            state     <= state_n;
            valid_0_0 <= load;
            gap_cnt   <= (state == GAP && state_n == GAP) ? gap_cnt + GW'(1) : '0;
            if (load) begin
                rd_cnt <= rd_last ? '0 : rd_cnt + CW'(1);
                if (rd_last) rd_bank <= ~rd_bank;
            end
        end
    end

    // Next state and beat-load decode.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    load    = 1'b1;
                    state_n = STREAM;
                end
            end
            STREAM: begin
                load = 1'b1;
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES)) begin
                    if (full[rd_bank]) begin
                        load    = 1'b1;
                        state_n = STREAM;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (rd_clr) state_n = GAP;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        framer_bank #(
            .WIDTH       (WIDTH),
            .DATA_WIDTH  (DATA_WIDTH),
            .FRAME_BEATS (FRAME_BEATS)
        ) u_bank (
            .clk      (clk),
            .rstn     (rstn),
            .wr_en    (accept && (wr_bank == 1'(b))),
            .waddr    (wr_cnt),
            .wdata_re (din_re),
            .wdata_im (din_im),
            .rd_en    (load && (rd_bank == 1'(b))),
            .raddr    (rd_cnt),
            .rdata_re (bank_re[b]),
            .rdata_im (bank_im[b])
        );
    end

    // Idle bank read registers hold zero, so OR-ing selects the active one
    // and yields zero when nothing was loaded.
    assign dout_re = bank_re[0] | bank_re[1];
    assign dout_im = bank_im[0] | bank_im[1];

endmodule

// File: tb/tb_fft_in_framer.sv
// Self-checking bench for fft_in_framer: scenario table driven against a
// frame-level schedule model (frame start = max(completion+1, previous
// start + FRAME_BEATS + GAP_CYCLES)), plus hand-written reset and latency
// sequences.
module tb_fft_in_framer;
    import fft_in_framer_pkg::*;

    localparam int W  = int'(DEF_WIDTH);
    localparam int L  = int'(DEF_DATA_WIDTH);
    localparam int F  = int'(DEF_FRAME_BEATS);
    localparam int G  = int'(DEF_GAP_CYCLES);
    localparam int BW = W * L;

    logic clk = 1'b0;
    logic rstn, in_valid, in_ready, valid_0_0;
    logic [L-1:0][W-1:0] din_re, din_im, dout_re, dout_im;

    fft_in_framer #(
        .WIDTH       (DEF_WIDTH),
        .DATA_WIDTH  (DEF_DATA_WIDTH),
        .FRAME_BEATS (DEF_FRAME_BEATS),
        .GAP_CYCLES  (DEF_GAP_CYCLES)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din_re    (din_re),
        .din_im    (din_im),
        .dout_re   (dout_re),
        .dout_im   (dout_im),
        .valid_0_0 (valid_0_0)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    vmode;        // 0 always, 1 every other cycle, 2 random
        int    dmode;        // 0 ramp, 1 extremes, 2 impulse, 3 random
        int    frames;
        int    rst_after;    // reset after this beat index is accepted, -1 none
        int    post_frames;  // frames sent after that reset
        int    exp_valid;    // total valid_0_0 cycles
        int    exp_full_runs;
        int    exp_ready_low; // longest in_ready low run, -1 to skip
    } vec_t;

    vec_t vecs [7];

    int n_chk = 0;
    int n_pass = 0;

    // Reference model state
    logic [BW-1:0] q_re[$], q_im[$], p_re[$], p_im[$];
    int  start_q[$];
    int  last_s, edge_n;
    logic exp_ready;

    // Observed statistics per scenario
    int obs_valid, obs_full_runs, cur_run, cur_low, max_low;

    task automatic check(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, edge_n);
    endtask

    task automatic model_clear();
        q_re.delete(); q_im.delete(); p_re.delete(); p_im.delete();
        start_q.delete();
        last_s    = -100000;
        exp_ready = 1'b1;
    endtask

    task automatic obs_clear();
        obs_valid = 0; obs_full_runs = 0; cur_run = 0; cur_low = 0; max_low = 0;
    endtask

    function automatic void gen(input int dm, input int n,
                                output logic [BW-1:0] re, output logic [BW-1:0] im);
        int k, fr, r, i;
        k  = n % F;
        fr = n / F;
        re = '0;
        im = '0;
        for (int l = 0; l < L; l++) begin
            case (dm)
                0:       begin r = k * 16 + l - 256 + fr * 5; i = -r; end
                1:       begin r = 255; i = -256; end
                2:       begin r = (k == 0 && l == 0) ? 100 : 0; i = 0; end
                default: begin r = int'($urandom); i = int'($urandom); end
            endcase
            re[l*W +: W] = W'(r);
            im[l*W +: W] = W'(i);
        end
    endfunction

    // Apply current inputs across one edge, update the model, check outputs.
    task automatic cycle();
        logic acc, ev;
        logic [BW-1:0] er, ei;
        int idx, s;
        acc = rstn && in_valid && exp_ready;
        if (!rstn) begin
            model_clear();
        end else if (acc) begin
            p_re.push_back(din_re);
            p_im.push_back(din_im);
            if (p_re.size() == F) begin
                s = (edge_n + 2 > last_s + F + G) ? edge_n + 2 : last_s + F + G;
                start_q.push_back(s);
                last_s = s;
                for (int i = 0; i < F; i++) begin
                    q_re.push_back(p_re[i]);
                    q_im.push_back(p_im[i]);
                end
                p_re.delete();
                p_im.delete();
            end
        end
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        ev = 1'b0; er = '0; ei = '0;
        if (start_q.size() > 0 && edge_n >= start_q[0]) begin
            idx = edge_n - start_q[0];
            ev  = 1'b1;
            er  = q_re[idx];
            ei  = q_im[idx];
            if (idx == F - 1) begin
                void'(start_q.pop_front());
                repeat (F) begin
                    void'(q_re.pop_front());
                    void'(q_im.pop_front());
                end
            end
        end
        exp_ready = (start_q.size() < 2);
        check("valid_0_0", BW'(valid_0_0), BW'(ev));
        check("dout_re", dout_re, er);
        check("dout_im", dout_im, ei);
        check("in_ready", BW'(in_ready), BW'(exp_ready));
        if (valid_0_0) begin
            obs_valid++;
            cur_run++;
        end else begin
            if (cur_run == F) obs_full_runs++;
            cur_run = 0;
        end
        if (!in_ready) begin
            cur_low++;
            if (cur_low > max_low) max_low = cur_low;
        end else begin
            cur_low = 0;
        end
    endtask

    task automatic reset_cycle();
        rstn     = 1'b0;
        in_valid = 1'b0;
        cycle();
        rstn     = 1'b1;
        check("rst_valid", BW'(valid_0_0), BW'(0));
        check("rst_dout_re", dout_re, '0);
        check("rst_ready", BW'(in_ready), BW'(1));
    endtask

    initial begin
        int sent, total, guard;
        logic post, have, tgl, acc;
        logic [BW-1:0] cur_re, cur_im, b0_re, b0_im, b1_re, b1_im;

        vecs[0] = '{"single",   0, 0, 1, -1, 0, 32,  1, 0};
        vecs[1] = '{"cont4",    0, 0, 4, -1, 0, 128, 4, 17};
        vecs[2] = '{"toggle",   1, 0, 2, -1, 0, 64,  2, 0};
        vecs[3] = '{"midreset", 0, 0, 2, 52, 1, 53,  1, 0};
        vecs[4] = '{"extreme",  0, 1, 2, -1, 0, 64,  2, 0};
        vecs[5] = '{"impulse",  0, 2, 1, -1, 0, 32,  1, 0};
        vecs[6] = '{"random",   2, 3, 3, -1, 0, 96,  3, -1};

        rstn = 1'b0; in_valid = 1'b0; din_re = '0; din_im = '0;
        edge_n = 0;
        model_clear();
        obs_clear();
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            reset_cycle();
            obs_clear();
            sent = 0; total = vecs[v].frames * F; post = 1'b0;
            have = 1'b0; tgl = 1'b1; guard = 0;
            cur_re = '0; cur_im = '0;
            while (sent < total && guard < 3000) begin
                guard++;
                case (vecs[v].vmode)
                    0:       in_valid = 1'b1;
                    1:       begin in_valid = tgl; tgl = ~tgl; end
                    default: in_valid = ($urandom_range(0, 3) != 0);
                endcase
                if (!have) begin
                    gen(vecs[v].dmode, sent, cur_re, cur_im);
                    have = 1'b1;
                end
                if (in_valid) begin
                    din_re = cur_re; din_im = cur_im;
                end else begin
                    din_re = BW'({$urandom, $urandom, $urandom, $urandom, $urandom});
                    din_im = BW'({$urandom, $urandom, $urandom, $urandom, $urandom});
                end
                acc = in_valid && exp_ready;
                cycle();
                if (acc) begin
                    sent++;
                    have = 1'b0;
                    if (!post && vecs[v].rst_after >= 0 && sent == vecs[v].rst_after + 1) begin
                        reset_cycle();
                        post  = 1'b1;
                        sent  = 0;
                        total = vecs[v].post_frames * F;
                    end
                end
            end
            check({vecs[v].name, "_beats_sent"}, BW'(sent), BW'(total));
            in_valid = 1'b0;
            for (int i = 0; i < 600 && start_q.size() > 0; i++) cycle();
            repeat (G + 3) cycle();
            check({vecs[v].name, "_drained"}, BW'(start_q.size()), BW'(0));
            check({vecs[v].name, "_valid_cycles"}, BW'(obs_valid), BW'(vecs[v].exp_valid));
            check({vecs[v].name, "_full_runs"}, BW'(obs_full_runs), BW'(vecs[v].exp_full_runs));
            if (vecs[v].exp_ready_low >= 0)
                check({vecs[v].name, "_ready_low_max"}, BW'(max_low), BW'(vecs[v].exp_ready_low));
        end

        // Hand-written latency sequence: valid rises one edge after the last
        // beat is accepted, carrying beat 0, then beat 1.
        reset_cycle();
        gen(0, 0, b0_re, b0_im);
        gen(0, 1, b1_re, b1_im);
        in_valid = 1'b1;
        for (int k = 0; k < F; k++) begin
            gen(0, k, cur_re, cur_im);
            din_re = cur_re; din_im = cur_im;
            cycle();
            if (k < F - 1)
                check("lat_no_early_valid", BW'(valid_0_0), BW'(0));
        end
        in_valid = 1'b0;
        cycle();
        check("lat_valid_rise", BW'(valid_0_0), BW'(1));
        check("lat_beat0_re", dout_re, b0_re);
        check("lat_beat0_im", dout_im, b0_im);
        cycle();
        check("lat_beat1_re", dout_re, b1_re);
        repeat (F + G) cycle();
        check("lat_idle_valid", BW'(valid_0_0), BW'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fft_in_framer.md
FFT_IN_FRAMER -- requirements
Module: fft_in_framer

Interface
REQ-001 Parameter WIDTH, default 9: signed bit width of each real and imaginary sample.
REQ-002 Parameter DATA_WIDTH, default 16: number of parallel lanes per beat.
REQ-003 Parameter FRAME_BEATS, default 32: number of beats per FFT frame (512 points / 16 lanes).
REQ-004 Parameter GAP_CYCLES, default 17: number of cycles valid_0_0 is held low between frames so the downstream butterfly drains.
REQ-005 clk  in  1  single clock; all logic samples on the rising edge.
REQ-006 rstn  in  1  reset, synchronous and active-low.
REQ-007 in_valid  in  1  upstream beat valid.
REQ-008 in_ready  out  1  framer can accept a beat.
REQ-009 din_re, din_im  in  DATA_WIDTH x WIDTH signed  input lanes.
REQ-010 dout_re, dout_im  out  DATA_WIDTH x WIDTH signed  registered output lanes to butterfly_0_0.
REQ-011 valid_0_0  out  1  high for exactly FRAME_BEATS consecutive cycles per frame; drives butterfly_0_0 valid_0_0.

Function
REQ-012 Storage shall be two banks (ping-pong), each holding FRAME_BEATS beats of all lanes, re and im, with a registered full flag per bank.
REQ-013 A beat shall be accepted on an edge where in_valid and in_ready are both 1; it is written to wr_bank at address wr_cnt, and wr_cnt increments.
REQ-014 in_ready shall equal NOT full[wr_bank], decoded from registers only, with no combinational path from in_valid.
REQ-015 On acceptance of beat FRAME_BEATS-1, full[wr_bank] shall be set, wr_cnt shall wrap to 0, and wr_bank shall toggle on the same edge.
REQ-016 The output FSM shall have three states: IDLE, STREAM and GAP.
REQ-017 IDLE to STREAM: on an edge where full[rd_bank]=1, beat 0 is loaded into dout and valid_0_0 becomes 1.
REQ-018 STREAM: one beat is loaded per edge and rd_cnt increments; no stalls are permitted.
REQ-019 On the edge that loads beat FRAME_BEATS-1, the FSM shall clear full[rd_bank], toggle rd_bank and enter GAP.
REQ-020 GAP shall hold valid_0_0 at 0 for exactly GAP_CYCLES cycles; it then goes to STREAM if full[rd_bank]=1, else to IDLE.
REQ-021 Latency: if beat FRAME_BEATS-1 is accepted at edge E and the FSM is IDLE, valid_0_0 rises at edge E+1 with beat 0 on dout.
REQ-022 When valid_0_0=0, dout shall hold 0.
REQ-023 Data shall pass unmodified; lane order and beat order are preserved.
REQ-024 Simultaneous clear of full[b] (read end) and wr_bank toggling to b on the same edge is legal; in_ready is 1 in the following cycle.
REQ-025 A bank's full flag shall never be set and cleared on the same edge.
REQ-026 in_valid=1 while in_ready=0 shall not be accepted, and the input beat is not consumed.
REQ-027 Gaps in in_valid within a frame shall be tolerated; only accepted beats count.

Reset
REQ-028 With rstn=0 at an edge, the following shall clear: full[1:0], wr_cnt, rd_cnt, wr_bank, rd_bank, the GAP counter, dout, and valid_0_0; the FSM goes to IDLE.
REQ-029 Reset mid-frame shall discard partial and unread frames; in_ready is 1 in the first cycle after rstn returns to 1.
REQ-030 Bank memory contents need not be reset.

Structure
REQ-031 A shared FFT package shall hold the default WIDTH, DATA_WIDTH, FRAME_BEATS and GAP_CYCLES, plus the FSM state enum.
REQ-032 One sub-module, framer_bank, shall implement a single synchronous-write, registered-read bank; it is instantiated twice.

Verification
REQ-033 Single frame: beat k lane l re=k*16+l-256, im=-re -> valid_0_0 high 32 cycles starting edge E+1; dout matches in order.
REQ-034 Continuous in_valid, 4 frames -> frames 0-2 see no stall; after beat 95, in_ready is low 17 cycles; valid_0_0 gaps are exactly 17 cycles.
REQ-035 in_valid toggling every other cycle -> frame output identical and contiguous, with 32 cycles of valid_0_0.
REQ-036 rstn=0 for one edge after beat 20 of frame 1 while frame 0 streams -> valid_0_0=0 and dout=0 next cycle, in_ready=1; the next full frame streams correctly.
REQ-037 Extreme values: all lanes re=+255, im=-256 -> output bit-exact, with no sign corruption.
REQ-038 Chained with butterfly_0_0: an impulse in lane 0 of beat 0 -> butterfly outputs lane 0 = impulse in both halves, with bf0_0_o_en returning low before the next valid_0_0 rise.
